acc_core_multi: RTL and testbench
=================================

Name: acc_core_multi

Overview:
Parametrised successor to the single-lane accumulator core. It sums a programmed number of valid samples across NUM_LANES parallel lanes. Each lane supports signed or unsigned operands and optional saturation. After the last sample, the block presents all lane results with a one-tick valid. It sits between a memory-read streamer, which drives number_i/valid_i, and the result write-back logic.

Parameters:
IN_DATA_WIDTH, 8, width of one lane operand
DWIDTH, 16, width of one lane accumulator/result
NUM_LANES, 4, number of parallel accumulation lanes
LEN_WIDTH, 8, width of the sample-count field len_i
SATURATE, 0, 1 = clamp on overflow; 0 = wrap

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
run_i  in  1  start pulse; latches len_i and signed_i, clears lanes
len_i  in  LEN_WIDTH  number of valid samples to accumulate
signed_i  in  1  1 = two's-complement operands, 0 = unsigned
valid_i  in  1  number_i is valid this cycle
number_i  in  NUM_LANES*IN_DATA_WIDTH  lane k operand at bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]
busy_o  out  1  high in ACC and DONE states
valid_o  out  1  one-cycle tick; result_o/ovf_o are final
result_o  out  NUM_LANES*DWIDTH  lane k sum at [k*DWIDTH +: DWIDTH]
ovf_o  out  NUM_LANES  sticky per-lane overflow flag for the current run

Behaviour:
- Reset (async, any state): state IDLE; counter, len, mode, all accumulators, result_o, ovf_o, busy_o, valid_o = 0. Reset mid-run aborts the run with no valid_o.
- All outputs are registered. No combinational path from any input to any output. No #delays.
- FSM states:
  - IDLE: run_i sampled high latches len_i and signed_i, zeroes accumulators, ovf and the counter. Next state is ACC, or DONE if len_i==0.
  - ACC: each edge with valid_i=1 adds every lane operand and increments the counter. The edge that accepts sample number len moves to DONE.
  - DONE: valid_o=1 for exactly this one cycle, then IDLE unconditionally.
- Latency:
  - busy_o rises the cycle after run_i.
  - valid_o rises the cycle after the last accepted sample, with final results on the same cycle.
  - len=0: valid_o is high the cycle after run_i, with results 0.
- run_i while busy_o=1 is ignored; the run continues unaffected. valid_i outside ACC is ignored.
- valid_i gaps in ACC are allowed; the counter counts only accepted samples.
- Operand extension: signed mode sign-extends to DWIDTH+1; unsigned mode zero-extends. The sum is computed at DWIDTH+1 bits.
- Overflow detection:
  - Unsigned: carry out of DWIDTH.
  - Signed: true sum outside [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- On overflow, ovf_o[k] sets and stays set until the next accepted run_i.
  - SATURATE=1: the lane clamps to its max (unsigned all-ones; signed 0x7F..F) or, signed only, its min (0x80..0). It stays clamped only while further samples keep it out of range; a later in-range sum may pull it back.
  - SATURATE=0: the lane wraps modulo 2^DWIDTH.
- result_o and ovf_o hold their values after DONE until the next accepted run_i clears them, on the edge that samples run_i.
- Counter is LEN_WIDTH bits; max len = 2^LEN_WIDTH-1. The counter never wraps because the run terminates at len.

Decomposition:
- Package acc_pkg holds:
  - state encoding IDLE=2'd0, ACC=2'd1, DONE=2'd2;
  - default width constants;
  - a helper function returning the signed/unsigned max/min for a given width.
- Sub-module acc_lane: one lane's extend, add, overflow detect, saturate/wrap and sticky ovf. It is instantiated NUM_LANES times via generate. The top level holds the FSM and counter.

Test Plan:
1. Unsigned, len=3; lane0 gets 10, 20, 30 with one idle cycle between the 2nd and 3rd -> valid_o one tick, the cycle after 30 is accepted; lane0 = 16'd60, ovf=0, busy_o then 0.
2. Signed, len=2; lane1 gets 8'hFF, 8'hFE; lane2 gets 8'h7F, 8'h01 -> lane1 = 16'hFFFD, lane2 = 16'h0080, no ovf.
3. DWIDTH=10 instance, SATURATE=1, len=5:
   - unsigned, all lanes 8'hFF -> results 10'h3FF, ovf_o = all ones;
   - signed, all lanes 8'h80 -> results 10'h200, ovf set.
   - Repeat with SATURATE=0, unsigned -> 1275 mod 1024 = 10'd251, ovf set.
4. len=0 -> valid_o the cycle after run_i; all results 0; busy_o high for exactly 1 cycle.
5. Abort and ignore:
   - run_i pulsed during ACC (len=4, after 2 samples) -> ignored; result = sum of 4 samples.
   - Separately, reset_n low after 2 samples -> all outputs 0, no valid_o; a new run with len=1, value 7 -> 7.
6. valid_i=1 with 8'h55 while IDLE, and in the DONE cycle -> no effect. Results hold until the next run_i, then read 0 the cycle after run_i.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and constants for the multi-lane accumulator core.
// Holds the FSM encoding, default widths and the saturation limit helper.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_IN_DATA_WIDTH = 8;
    localparam int DEF_DWIDTH        = 16;
    localparam int DEF_NUM_LANES     = 4;
    localparam int DEF_LEN_WIDTH     = 8;
    localparam int LIM_W             = 64;

    // Largest (hi=1) or smallest (hi=0) value representable in w bits.
    function automatic logic [LIM_W-1:0] lim_val(input int w, input logic sgn, input logic hi);
        logic [LIM_W-1:0] ones;
        ones = {LIM_W{1'b1}} >> (LIM_W - w);
        if (!sgn) begin
            lim_val = hi ? ones : '0;
        end else begin
            lim_val = hi ? (ones >> 1) : (ones ^ (ones >> 1));
        end
    endfunction

endpackage

// File: rtl/acc_core_multi_if.sv
// Streamer-to-core bundle: run/sample inputs and registered result outputs.
interface acc_core_multi_if
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int DWIDTH        = DEF_DWIDTH,
    parameter int NUM_LANES     = DEF_NUM_LANES,
    parameter int LEN_WIDTH     = DEF_LEN_WIDTH
) ();

    logic                           run_i;
    logic [LEN_WIDTH-1:0]           len_i;
    logic                           signed_i;
    logic                           valid_i;
    logic [NUM_LANES*IN_DATA_WIDTH-1:0] number_i;
    logic                           busy_o;
    logic                           valid_o;
    logic [NUM_LANES*DWIDTH-1:0]    result_o;
    logic [NUM_LANES-1:0]           ovf_o;

    modport master (
        output run_i, len_i, signed_i, valid_i, number_i,
        input  busy_o, valid_o, result_o, ovf_o
    );

    modport slave (
        input  run_i, len_i, signed_i, valid_i, number_i,
        output busy_o, valid_o, result_o, ovf_o
    );

endinterface

// File: rtl/acc_lane.sv
// One accumulation lane: operand extension, add, overflow detection,
// saturate-or-wrap and a sticky overflow flag.
module acc_lane
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int DWIDTH        = DEF_DWIDTH,
    parameter int SATURATE      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     sgn_i,
    input  logic [IN_DATA_WIDTH-1:0] op_i,
    output logic [DWIDTH-1:0]        acc_o,
    output logic                     ovf_o
);

    localparam int SW = DWIDTH + 1;

    logic [DWIDTH-1:0]     acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic signed [SW-1:0]  op_ext, acc_ext, sum;
    logic                  ovf_now;

    // Out-of-range sums clamp toward the side they left, in signed mode the sign of the wide sum tells which.
    function automatic logic [DWIDTH-1:0] clamp(input logic signed [SW-1:0] s, input logic sgn,
                                                input logic ovf);
        if (!ovf || SATURATE == 0) begin
            clamp = s[DWIDTH-1:0];
        end else begin
            clamp = DWIDTH'(lim_val(DWIDTH, sgn, ~(sgn & s[SW-1])));
        end
    endfunction

    always_comb begin
        op_ext  = sgn_i ? {{(SW-IN_DATA_WIDTH){op_i[IN_DATA_WIDTH-1]}}, op_i}
                        : {{(SW-IN_DATA_WIDTH){1'b0}}, op_i};
        acc_ext = sgn_i ? {acc_q[DWIDTH-1], acc_q} : {1'b0, acc_q};
        sum     = acc_ext + op_ext;
        ovf_now = sgn_i ? (sum[SW-1] ^ sum[SW-2]) : sum[SW-1];
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            acc_d = clamp(sum, sgn_i, ovf_now);
            ovf_d = ovf_q | ovf_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/acc_core_multi.sv
// Multi-lane accumulator: FSM and sample counter, with one acc_lane per lane.
// Results and flags hold after DONE until the next accepted run.
module acc_core_multi
    import acc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int DWIDTH        = DEF_DWIDTH,
    parameter int NUM_LANES     = DEF_NUM_LANES,
    parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
    parameter int SATURATE      = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    acc_core_multi_if.slave  bus
);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic                 sgn_q, sgn_d;
    logic                 busy_q, busy_d, valid_q, valid_d;
    logic                 clr, add_en;
    logic [NUM_LANES*DWIDTH-1:0] res_w;
    logic [NUM_LANES-1:0]        ovf_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sgn_d   = sgn_q;
        clr     = 1'b0;
        add_en  = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.run_i) begin
                    clr     = 1'b1;
                    len_d   = bus.len_i;
                    sgn_d   = bus.signed_i;
                    cnt_d   = '0;
                    state_d = (bus.len_i == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (bus.valid_i) begin
                    add_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flags are derived from the next state so they line up with it once registered.
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        acc_lane #(
            .IN_DATA_WIDTH(IN_DATA_WIDTH),
            .DWIDTH       (DWIDTH),
            .SATURATE     (SATURATE)
        ) u_lane (
            .clk   (clk),
            .rst_n (reset_n),
            .clr_i (clr),
            .en_i  (add_en),
            .sgn_i (sgn_q),
            .op_i  (bus.number_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .acc_o (res_w[k*DWIDTH +: DWIDTH]),
            .ovf_o (ovf_w[k])
        );
    end

    assign bus.busy_o   = busy_q;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = res_w;
    assign bus.ovf_o    = ovf_w;

endmodule

// File: tb/tb_acc_core_multi.sv
// Directed bench for acc_core_multi: a 16-bit wrap instance and two 10-bit
// instances (saturating and wrapping) driven with identical stimulus.
module tb_acc_core_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run, sgn, vin;
    logic [7:0]  len;
    logic [31:0] num;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    acc_core_multi_if #(.DWIDTH(16)) b16 ();
    acc_core_multi_if #(.DWIDTH(10)) b10s ();
    acc_core_multi_if #(.DWIDTH(10)) b10w ();

    assign b16.run_i  = run;  assign b16.len_i  = len;  assign b16.signed_i  = sgn;
    assign b16.valid_i  = vin; assign b16.number_i  = num;
    assign b10s.run_i = run;  assign b10s.len_i = len;  assign b10s.signed_i = sgn;
    assign b10s.valid_i = vin; assign b10s.number_i = num;
    assign b10w.run_i = run;  assign b10w.len_i = len;  assign b10w.signed_i = sgn;
    assign b10w.valid_i = vin; assign b10w.number_i = num;

    acc_core_multi #(.DWIDTH(16), .SATURATE(0)) u16  (.clk(clk), .reset_n(reset_n), .bus(b16));
    acc_core_multi #(.DWIDTH(10), .SATURATE(1)) u10s (.clk(clk), .reset_n(reset_n), .bus(b10s));
    acc_core_multi #(.DWIDTH(10), .SATURATE(0)) u10w (.clk(clk), .reset_n(reset_n), .bus(b10w));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 0; sgn = 0; vin = 0; len = 0; num = 0;
        #12;
        checks++; if (b16.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b16.busy_o); end
        checks++; if (b16.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", b16.valid_o); end
        checks++; if (b16.result_o !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", b16.result_o); end
        checks++; if ({b16.ovf_o, b10s.ovf_o} !== 8'd0) begin errors++; $display("FAIL reset_ovf got %h want 0", {b16.ovf_o, b10s.ovf_o}); end
        #3 reset_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned_gap();
        run = 1; len = 3; sgn = 0; vin = 0;
        step();
        checks++; if (b16.busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_rise got %b want 1", b16.busy_o); end
        run = 0; vin = 1; num = 32'd10; step();
        num = 32'd20; step();
        vin = 0; step();
        checks++; if (b16.valid_o !== 1'b0) begin errors++; $display("FAIL t1_valid_early got %b want 0", b16.valid_o); end
        vin = 1; num = 32'd30; step();
        vin = 0;
        checks++; if (b16.valid_o !== 1'b1) begin errors++; $display("FAIL t1_valid got %b want 1", b16.valid_o); end
        checks++; if (b16.result_o !== 64'd60) begin errors++; $display("FAIL t1_result got %h want 3c", b16.result_o); end
        checks++; if (b16.ovf_o !== 4'd0) begin errors++; $display("FAIL t1_ovf got %h want 0", b16.ovf_o); end
        step();
        checks++; if ({b16.valid_o, b16.busy_o} !== 2'b00) begin errors++; $display("FAIL t1_after got %b want 00", {b16.valid_o, b16.busy_o}); end
        checks++; if (b16.result_o !== 64'd60) begin errors++; $display("FAIL t1_hold got %h want 3c", b16.result_o); end
    endtask

    task automatic test_signed();
        run = 1; len = 2; sgn = 1; vin = 0; step();
        run = 0; vin = 1; num = {8'h00, 8'h7F, 8'hFF, 8'h00}; step();
        num = {8'h00, 8'h01, 8'hFE, 8'h00}; step();
        vin = 0;
        checks++; if (b16.valid_o !== 1'b1) begin errors++; $display("FAIL t2_valid got %b want 1", b16.valid_o); end
        checks++; if (b16.result_o !== {16'h0000, 16'h0080, 16'hFFFD, 16'h0000}) begin errors++; $display("FAIL t2_result16 got %h want 00000080fffd0000", b16.result_o); end
        checks++; if (b10s.result_o !== {10'h000, 10'h080, 10'h3FD, 10'h000}) begin errors++; $display("FAIL t2_result10 got %h want %h", b10s.result_o, {10'h000, 10'h080, 10'h3FD, 10'h000}); end
        checks++; if ({b16.ovf_o, b10s.ovf_o} !== 8'd0) begin errors++; $display("FAIL t2_ovf got %h want 0", {b16.ovf_o, b10s.ovf_o}); end
        step();
    endtask

    task automatic test_overflow();
        run = 1; len = 5; sgn = 0; vin = 0; step();
        run = 0; vin = 1; num = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) step();
        vin = 0;
        checks++; if (b10s.valid_o !== 1'b1) begin errors++; $display("FAIL t3u_valid got %b want 1", b10s.valid_o); end
        checks++; if (b10s.result_o !== {4{10'h3FF}}) begin errors++; $display("FAIL t3u_sat got %h want %h", b10s.result_o, {4{10'h3FF}}); end
        checks++; if (b10s.ovf_o !== 4'hF) begin errors++; $display("FAIL t3u_sat_ovf got %h want f", b10s.ovf_o); end
        checks++; if (b10w.result_o !== {4{10'd251}}) begin errors++; $display("FAIL t3u_wrap got %h want %h", b10w.result_o, {4{10'd251}}); end
        checks++; if (b10w.ovf_o !== 4'hF) begin errors++; $display("FAIL t3u_wrap_ovf got %h want f", b10w.ovf_o); end
        checks++; if (b16.result_o !== {4{16'h04FB}} || b16.ovf_o !== 4'h0) begin errors++; $display("FAIL t3u_w16 got %h/%h want %h/0", b16.result_o, b16.ovf_o, {4{16'h04FB}}); end
        step();
        run = 1; len = 5; sgn = 1; step();
        run = 0; vin = 1; num = 32'h8080_8080;
        for (int i = 0; i < 5; i++) step();
        vin = 0;
        checks++; if (b10s.result_o !== {4{10'h200}}) begin errors++; $display("FAIL t3s_sat got %h want %h", b10s.result_o, {4{10'h200}}); end
        checks++; if (b10s.ovf_o !== 4'hF) begin errors++; $display("FAIL t3s_sat_ovf got %h want f", b10s.ovf_o); end
        checks++; if (b10w.result_o !== {4{10'h180}} || b10w.ovf_o !== 4'hF) begin errors++; $display("FAIL t3s_wrap got %h/%h want %h/f", b10w.result_o, b10w.ovf_o, {4{10'h180}}); end
        checks++; if (b16.result_o !== {4{16'hFD80}} || b16.ovf_o !== 4'h0) begin errors++; $display("FAIL t3s_w16 got %h/%h want %h/0", b16.result_o, b16.ovf_o, {4{16'hFD80}}); end
        step();
    endtask

    task automatic test_len_zero();
        run = 1; len = 0; sgn = 0; vin = 0; step();
        run = 0;
        checks++; if ({b16.valid_o, b16.busy_o} !== 2'b11) begin errors++; $display("FAIL t4_done got %b want 11", {b16.valid_o, b16.busy_o}); end
        checks++; if (b16.result_o !== 64'd0 || b10s.ovf_o !== 4'd0) begin errors++; $display("FAIL t4_zero got %h/%h want 0/0", b16.result_o, b10s.ovf_o); end
        step();
        checks++; if ({b16.valid_o, b16.busy_o} !== 2'b00) begin errors++; $display("FAIL t4_idle got %b want 00", {b16.valid_o, b16.busy_o}); end
    endtask

    task automatic test_run_ignored();
        run = 1; len = 4; sgn = 0; vin = 0; step();
        run = 0; vin = 1; num = 32'd1; step();
        num = 32'd2; step();
        run = 1; len = 9; num = 32'd3; step();
        run = 0;
        checks++; if (b16.valid_o !== 1'b0) begin errors++; $display("FAIL t5_valid_early got %b want 0", b16.valid_o); end
        num = 32'd4; step();
        vin = 0;
        checks++; if (b16.valid_o !== 1'b1 || b16.result_o !== 64'd10) begin errors++; $display("FAIL t5_result got %b/%h want 1/a", b16.valid_o, b16.result_o); end
        step();
    endtask

    task automatic test_abort();
        int seen = 0;
        run = 1; len = 4; sgn = 0; vin = 0; step();
        run = 0; vin = 1; num = 32'd5; step();
        step();
        vin = 0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({b16.busy_o, b16.valid_o} !== 2'b00 || b16.result_o !== 64'd0) begin errors++; $display("FAIL t5_abort got %b/%h want 00/0", {b16.busy_o, b16.valid_o}, b16.result_o); end
        #3 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (b16.valid_o === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL t5_no_valid got %0d ticks want 0", seen); end
        run = 1; len = 1; step();
        run = 0; vin = 1; num = 32'd7; step();
        vin = 0;
        checks++; if (b16.valid_o !== 1'b1 || b16.result_o !== 64'd7) begin errors++; $display("FAIL t5_rerun got %b/%h want 1/7", b16.valid_o, b16.result_o); end
        step();
    endtask

    task automatic test_valid_outside_acc();
        vin = 1; num = 32'h5555_5555; step(); step();
        checks++; if (b16.result_o !== 64'd7 || {b16.valid_o, b16.busy_o} !== 2'b00) begin errors++; $display("FAIL t6_idle_ignore got %h/%b want 7/00", b16.result_o, {b16.valid_o, b16.busy_o}); end
        run = 1; len = 1; sgn = 0; step();
        run = 0;
        checks++; if (b16.result_o !== 64'd0 || b16.busy_o !== 1'b1) begin errors++; $display("FAIL t6_clear got %h/%b want 0/1", b16.result_o, b16.busy_o); end
        num = 32'd3; step();
        checks++; if (b16.valid_o !== 1'b1 || b16.result_o !== 64'd3) begin errors++; $display("FAIL t6_result got %b/%h want 1/3", b16.valid_o, b16.result_o); end
        num = 32'h5555_5555; step();
        vin = 0;
        checks++; if (b16.result_o !== 64'd3 || {b16.valid_o, b16.busy_o} !== 2'b00) begin errors++; $display("FAIL t6_done_ignore got %h/%b want 3/00", b16.result_o, {b16.valid_o, b16.busy_o}); end
    endtask

    initial begin
        test_reset();
        test_unsigned_gap();
        test_signed();
        test_overflow();
        test_len_zero();
        test_run_ignored();
        test_abort();
        test_valid_outside_acc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
